// File: rtl/dvp_rgb565_tx.sv
// DVP camera-side transmitter: RGB565 valid/ready stream -> vsync/href/8-bit dout on pclk, low byte first.
// Outputs trail the FSM by one cycle; pix_ready only on byte phase 0 of active cycles, underflow sends FILL.
module dvp_rgb565_tx #(
  parameter int          H_ACTIVE    = 640,
  parameter int          H_BLANK     = 144,
  parameter int          V_ACTIVE    = 480,
  parameter int          VSYNC_LINES = 3,
  parameter int          V_BACK      = 17,
  parameter int          V_FRONT     = 10,
  parameter logic [15:0] FILL        = 16'h0000
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  dout,
  output logic        href,
  output logic        vsync,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow,
  input  logic        clr_underflow,
  output logic [15:0] frame_cnt
);

  localparam int ACT_LEN  = 2 * H_ACTIVE;
  localparam int LINE_LEN = ACT_LEN + H_BLANK;
  localparam int VS_LEN   = VSYNC_LINES * LINE_LEN;
  localparam int VB_LEN   = V_BACK * LINE_LEN;
  localparam int VF_LEN   = V_FRONT * LINE_LEN;
  localparam int MAX_V1   = (VS_LEN > VB_LEN) ? VS_LEN : VB_LEN;
  localparam int MAX_V    = (MAX_V1 > VF_LEN) ? MAX_V1 : VF_LEN;
  localparam int MAX_CNT  = (MAX_V > LINE_LEN) ? MAX_V : LINE_LEN;
  localparam int CW       = $clog2(MAX_CNT);
  localparam int LW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_HBLANK,
    S_VFRONT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] line;
  logic          phase;
  logic [7:0]    hi_byte;
  logic          last;

  assign pix_ready = (state == S_ACTIVE) && !phase;
  assign busy      = (state != S_IDLE);

  // last cycle of the current state; the single counter is reused by every state
  always_comb begin
    last = 1'b0;
    case (state)
      S_VSYNC:  last = (cnt == CW'(VS_LEN - 1));
      S_VBACK:  last = (cnt == CW'(VB_LEN - 1));
      S_ACTIVE: last = (cnt == CW'(ACT_LEN - 1));
      S_HBLANK: last = (cnt == CW'(H_BLANK - 1));
      S_VFRONT: last = (cnt == CW'(VF_LEN - 1));
      default:  last = 1'b0;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      line       <= '0;
      phase      <= 1'b0;
      hi_byte    <= 8'h00;
      dout       <= 8'h00;
      href       <= 1'b0;
      vsync      <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      frame_cnt  <= 16'h0000;
    end else begin
      href       <= (state == S_ACTIVE);
      vsync      <= (state == S_VSYNC);
      frame_done <= 1'b0;
      dout       <= 8'h00;
      cnt        <= (state == S_IDLE || last) ? '0 : cnt + CW'(1);

      if (clr_underflow)
        underflow <= 1'b0;

      if (state == S_ACTIVE) begin
        phase <= ~phase;
        if (!phase) begin
          if (pix_valid) begin
            dout    <= pix_in[7:0];
            hi_byte <= pix_in[15:8];
          end else begin
            // source starved: emit FILL in this slot, the pending pixel waits for the next one
            dout      <= FILL[7:0];
            hi_byte   <= FILL[15:8];
            underflow <= 1'b1;
          end
        end else begin
          dout <= hi_byte;
        end
      end else begin
        phase <= 1'b0;
      end

      case (state)
        S_IDLE:   if (enable) state <= S_VSYNC;
        S_VSYNC:  if (last) state <= S_VBACK;
        S_VBACK:  if (last) state <= S_ACTIVE;
        S_ACTIVE: if (last) state <= S_HBLANK;
        S_HBLANK: begin
          if (last) begin
            if (line == LW'(V_ACTIVE - 1)) begin
              line  <= '0;
              state <= S_VFRONT;
            end else begin
              line  <= line + LW'(1);
              state <= S_ACTIVE;
            end
          end
        end
        S_VFRONT: begin
          if (last) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            state      <= enable ? S_VSYNC : S_IDLE;
          end
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
